// File: rtl/mod_mult.sv
// mod_mult: bit-serial shift-and-add modular multiplier, optional err port and operand range check via MODMULT_RANGE_CHECK_EN
module mod_mult #(
    parameter int MPWID = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds,
    input  logic [MPWID-1:0] mpand,
    input  logic [MPWID-1:0] mplier,
    input  logic [MPWID-1:0] modulus,
    output logic [MPWID-1:0] product,
    output logic             ready
`ifdef MODMULT_RANGE_CHECK_EN
    ,
    output logic             err
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [MPWID-1:0] mc, mp, m, acc;
    logic [MPWID-1:0] mc_n, mp_n, m_n, acc_n, product_n;
    logic ready_n;
    logic [MPWID:0] sum, dbl;
    logic [MPWID-1:0] sum_red, dbl_red;
    // one extra bit keeps the carry; operands below m make one subtraction enough
    assign sum = {1'b0, acc} + {1'b0, mc};
    assign dbl = {mc, 1'b0};
    assign sum_red = (sum >= {1'b0, m}) ? MPWID'(sum - {1'b0, m}) : sum[MPWID-1:0];
    assign dbl_red = (dbl >= {1'b0, m}) ? MPWID'(dbl - {1'b0, m}) : dbl[MPWID-1:0];
`ifdef MODMULT_RANGE_CHECK_EN
    logic bad, err_n;
    assign bad = (mpand >= modulus) || (mplier >= modulus) || (modulus == '0);
`endif
    always_comb begin
        state_n   = state;
        mc_n      = mc;
        mp_n      = mp;
        m_n       = m;
        acc_n     = acc;
        product_n = product;
        ready_n   = ready;
`ifdef MODMULT_RANGE_CHECK_EN
        err_n     = err;
`endif
        if (ds) begin
            mc_n    = mpand;
            mp_n    = mplier;
            m_n     = modulus;
            acc_n   = '0;
            ready_n = 1'b0;
            state_n = BUSY;
`ifdef MODMULT_RANGE_CHECK_EN
            err_n   = bad;
            state_n = bad ? DONE : BUSY;
`endif
        end else if (state == BUSY) begin
            state_n = (mp == '0) ? DONE : BUSY;
            acc_n   = (mp != '0 && mp[0]) ? sum_red : acc;
            mc_n    = (mp != '0) ? dbl_red : mc;
            mp_n    = mp >> 1;
        end else if (state == DONE) begin
            product_n = acc;
            ready_n   = 1'b1;
            state_n   = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mc      <= '0;
            mp      <= '0;
            m       <= '0;
            acc     <= '0;
            product <= '0;
            ready   <= 1'b0;
`ifdef MODMULT_RANGE_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            mc      <= mc_n;
            mp      <= mp_n;
            m       <= m_n;
            acc     <= acc_n;
            product <= product_n;
            ready   <= ready_n;
`ifdef MODMULT_RANGE_CHECK_EN
            err     <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_mod_mult.sv
// tb_mod_mult: scoreboard bench for mod_mult, checks results, latency, restart and reset abort
module tb_mod_mult;
    logic        clk, reset, ds, ready;
    logic [31:0] mpand, mplier, modulus, product;
`ifdef MODMULT_RANGE_CHECK_EN
    logic        err;
`endif
    int n_chk = 0, n_fail = 0, seen883 = 0;
    logic [31:0] sb[$];

    mod_mult #(.MPWID(32)) dut (
        .clk(clk), .reset(reset), .ds(ds), .mpand(mpand), .mplier(mplier),
        .modulus(modulus), .product(product), .ready(ready)
`ifdef MODMULT_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int blen(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic [31:0] mo);
        @(negedge clk);
        mpand = a; mplier = b; modulus = mo; ds = 1'b1;
        @(negedge clk);
        ds = 1'b0;
        mpand = $urandom; mplier = $urandom; modulus = $urandom;
    endtask

    task automatic wait_ready(input string tag, input int lat);
        int n = 0;
        while (!ready && n < 200) begin
            if (product == 32'd883) seen883++;
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_prod"}, product, sb.pop_front());
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] mo);
        sb.push_back(32'((64'(a) * 64'(b)) % 64'(mo)));
        pulse(a, b, mo);
        wait_ready(tag, blen(b) + 2);
    endtask

    initial begin
        reset = 1'b1; ds = 1'b0; mpand = '0; mplier = '0; modulus = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", ready, 0);
        check("rst_prod", product, 0);
        repeat (5) @(negedge clk);
        check("idle_ready", ready, 0);
        check("idle_prod", product, 0);

        run("a929b31", 929, 31, 997);
        repeat (4) @(negedge clk);
        check("hold_ready", ready, 1);
        check("hold_prod", product, 883);
        run("a31b929", 31, 929, 997);
        run("carry", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run("b0", 12345, 0, 99991);
        run("a0", 0, 929, 997);

        seen883 = 0;
        pulse(31, 929, 997);
        repeat (2) begin
            if (product == 32'd883) seen883++;
            @(negedge clk);
        end
        sb.push_back(2);
        pulse(5, 7, 11);
        wait_ready("restart", 5);
        repeat (20) begin
            if (product == 32'd883) seen883++;
            @(negedge clk);
        end
        check("no883", seen883, 0);

        pulse(929, 31, 997);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", ready, 0);
        check("abort_prod", product, 0);
        repeat (10) @(negedge clk);
        check("abort_idle", ready, 0);
        run("after_rst", 929, 31, 997);

`ifdef MODMULT_RANGE_CHECK_EN
        check("err_legal", err, 0);
        sb.push_back(0);
        pulse(997, 5, 997);
        wait_ready("range", 1);
        check("err_set", err, 1);
        run("err_clr", 5, 7, 11);
        check("err_legal2", err, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
